// File: rtl/street_light_btn_tx.sv
// Button-to-request transmitter: synchronizes and debounces a raw push-button and raises one
// req/ack-handshaked request on b per press. Optional long-press flag: STREET_LIGHT_LONG_PRESS_EN.
module street_light_btn_tx #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLDOFF_CYCLES  = 8,
  parameter int LONG_CYCLES     = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_raw,
  input  logic       ack,
  output logic       b,
  output logic       busy,
  output logic [7:0] press_cnt,
  output logic       long_press
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_DB_PRESS = 3'd1;
  localparam logic [2:0] ST_REQ      = 3'd2;
  localparam logic [2:0] ST_WAIT_REL = 3'd3;
  localparam logic [2:0] ST_DB_REL   = 3'd4;
  localparam logic [2:0] ST_HOLDOFF  = 3'd5;

  localparam logic [7:0] DB_LIM = 8'(DEBOUNCE_CYCLES);
  localparam logic [7:0] HO_LIM = 8'(HOLDOFF_CYCLES);

  localparam bit CFG_OK = (DEBOUNCE_CYCLES >= 2) && (DEBOUNCE_CYCLES <= 255) &&
                          (HOLDOFF_CYCLES >= 1) && (HOLDOFF_CYCLES <= 255) &&
                          (LONG_CYCLES >= 1) && (LONG_CYCLES <= 65535);

  if (!CFG_OK) begin : g_bad_cfg
    $error("street_light_btn_tx: parameter out of legal range");
  end

  logic       r_s1;
  logic       r_btn_s;
  logic [2:0] r_state;
  logic [7:0] r_cnt;
  logic       r_b;
  logic       r_busy;
  logic [7:0] r_press_cnt;

  logic [2:0] w_state_next;
  logic [7:0] w_cnt_next;
  logic [7:0] w_cnt_inc;
  logic       w_ack_take;

  // One shared saturating counter serves both debounce phases and the hold-off.
  always_comb begin
    w_cnt_inc    = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_ack_take   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_btn_s) begin
          w_state_next = ST_DB_PRESS;
          w_cnt_next   = 8'd1;
        end else begin
          w_cnt_next   = 8'd0;
        end
      end
      ST_DB_PRESS: begin
        if (r_cnt >= DB_LIM) begin
          w_state_next = ST_REQ;
          w_cnt_next   = 8'd0;
        end else if (!r_btn_s) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = 8'd0;
        end else begin
          w_cnt_next   = w_cnt_inc;
        end
      end
      ST_REQ: begin
        if (ack) begin
          w_state_next = ST_WAIT_REL;
          w_ack_take   = 1'b1;
        end
      end
      ST_WAIT_REL: begin
        if (!r_btn_s) begin
          w_state_next = ST_DB_REL;
          w_cnt_next   = 8'd1;
        end
      end
      ST_DB_REL: begin
        if (r_cnt >= DB_LIM) begin
          w_state_next = ST_HOLDOFF;
          w_cnt_next   = 8'd1;
        end else if (r_btn_s) begin
          w_state_next = ST_WAIT_REL;
          w_cnt_next   = 8'd0;
        end else begin
          w_cnt_next   = w_cnt_inc;
        end
      end
      ST_HOLDOFF: begin
        if (r_cnt >= HO_LIM) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = 8'd0;
        end else begin
          w_cnt_next   = w_cnt_inc;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = 8'd0;
      end
    endcase
  end

  // b and busy are decoded from the next state so both come straight from flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1        <= 1'b0;
      r_btn_s     <= 1'b0;
      r_state     <= ST_IDLE;
      r_cnt       <= 8'd0;
      r_b         <= 1'b0;
      r_busy      <= 1'b0;
      r_press_cnt <= 8'd0;
    end else begin
      r_s1        <= btn_raw;
      r_btn_s     <= r_s1;
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_b         <= (w_state_next == ST_REQ);
      r_busy      <= (w_state_next != ST_IDLE);
      if (w_ack_take) begin
        r_press_cnt <= r_press_cnt + 8'd1;
      end
    end
  end

  assign b         = r_b;
  assign busy      = r_busy;
  assign press_cnt = r_press_cnt;

`ifdef STREET_LIGHT_LONG_PRESS_EN
  localparam logic [15:0] LONG_LIM = 16'(LONG_CYCLES);

  logic [15:0] r_hold;
  logic        r_fired;
  logic        r_long;
  logic        w_in_window;
  logic        w_req_entry;

  assign w_in_window = (r_state == ST_REQ) || (r_state == ST_WAIT_REL) || (r_state == ST_DB_REL);
  assign w_req_entry = (w_state_next == ST_REQ) && (r_state != ST_REQ);

  // r_fired limits the flag to one pulse per press even if a bounce restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold  <= 16'd0;
      r_fired <= 1'b0;
      r_long  <= 1'b0;
    end else begin
      r_long <= 1'b0;
      if (w_req_entry) begin
        r_hold  <= 16'd0;
        r_fired <= 1'b0;
      end else if (w_in_window) begin
        if (!r_btn_s) begin
          r_hold <= 16'd0;
        end else if (r_hold != LONG_LIM) begin
          r_hold <= r_hold + 16'd1;
          if ((r_hold == LONG_LIM - 16'd1) && !r_fired) begin
            r_long  <= 1'b1;
            r_fired <= 1'b1;
          end
        end
      end
    end
  end

  assign long_press = r_long;
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_street_light_btn_tx.sv
// Scoreboard bench for street_light_btn_tx: button waveforms are planned up front, expected
// b/busy/long_press events are queued from the timing rules, and a monitor checks them.
module tb_street_light_btn_tx;
  localparam int D = 16;
  localparam int H = 8;
  localparam int L = 64;
`ifdef STREET_LIGHT_LONG_PRESS_EN
  localparam bit LP = 1'b1;
`else
  localparam bit LP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_raw = 1'b0;
  logic       ack = 1'b1;
  logic       b;
  logic       busy;
  logic [7:0] press_cnt;
  logic       long_press;

  street_light_btn_tx #(
    .DEBOUNCE_CYCLES(D),
    .HOLDOFF_CYCLES(H),
    .LONG_CYCLES(L)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_raw),
    .ack(ack),
    .b(b),
    .busy(busy),
    .press_cnt(press_cnt),
    .long_press(long_press)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int rise;
    int width;
    int cnt;
  } bexp_t;

  bexp_t qb[$];
  int    qbusy[$];
  int    qlong[$];
  bit    wave[$];
  int    model_cnt = 0;
  int    errors = 0;
  int    checks = 0;
  bit    mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT shows an event.
  initial begin
    bexp_t cur;
    int    rise_act;
    bit    have_cur;
    logic  pb;
    logic  pbusy;
    have_cur = 1'b0;
    rise_act = 0;
    pb = 1'b0;
    pbusy = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (b && !pb) begin
          if (qb.size() == 0) chk("unexpected_b_rise", cyc, -1);
          else begin
            cur = qb.pop_front();
            have_cur = 1'b1;
            rise_act = cyc;
            chk("b_rise_cycle", cyc, cur.rise);
          end
        end
        if (!b && pb && have_cur) begin
          chk("b_width", cyc - rise_act, cur.width);
          chk("press_cnt", int'(press_cnt), cur.cnt);
          $display("txn rise=%0d width=%0d press_cnt=%0d", rise_act, cyc - rise_act, press_cnt);
          have_cur = 1'b0;
        end
        if (!busy && pbusy) begin
          if (qbusy.size() == 0) chk("unexpected_busy_fall", cyc, -1);
          else chk("busy_fall_cycle", cyc, qbusy.pop_front());
        end
        if (long_press) begin
          if (qlong.size() == 0) chk("unexpected_long_press", cyc, -1);
          else chk("long_press_cycle", cyc, qlong.pop_front());
        end
      end
      pb = b;
      pbusy = busy;
    end
  end

  // wave[i] drives the edge t0+i; ack is high for edges >= ack_from; rst_n low at rst_edge.
  task automatic play(input int t0, input int ack_from, input int rst_edge);
    for (int i = 0; i < wave.size(); i++) begin
      btn_raw = wave[i];
      ack     = ((t0 + i) >= ack_from);
      rst_n   = ((t0 + i) == rst_edge) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (rst_edge != 0 && cyc == rst_edge) begin
        chk("rst_mid_b", int'(b), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_press_cnt", int'(press_cnt), 0);
      end
    end
    rst_n = 1'b1;
  endtask

  // Accepted press: nb rejected bounces, main high of lh cycles, nrel release bounces.
  task automatic press(input int nb, input int lh, input int k, input int nrel);
    int t0, e, r1, h, l;
    bexp_t x;
    wave.delete();
    @(negedge clk);
    t0 = cyc + 1;
    for (int j = 0; j < nb; j++) begin
      h = $urandom_range(D - 1, 1);
      l = $urandom_range(5, 1);
      qbusy.push_back(t0 + wave.size() + h + 2);
      repeat (h) wave.push_back(1'b1);
      repeat (l) wave.push_back(1'b0);
    end
    e = t0 + wave.size() + D + 2;
    model_cnt = (model_cnt + 1) % 256;
    x.rise = e;
    x.width = k;
    x.cnt = model_cnt;
    qb.push_back(x);
    if (LP && lh >= D + 1 + L) qlong.push_back(e + L);
    repeat (lh) wave.push_back(1'b1);
    for (int j = 0; j < nrel; j++) begin
      l = $urandom_range(D - 1, 1);
      h = $urandom_range(4, 1);
      repeat (l) wave.push_back(1'b0);
      repeat (h) wave.push_back(1'b1);
    end
    r1 = t0 + wave.size();
    qbusy.push_back(r1 + 2 + D + H);
    repeat (2 + D + H + $urandom_range(4, 1)) wave.push_back(1'b0);
    play(t0, (k == 1) ? 0 : e + k, 0);
  endtask

  task automatic bounce_only(input int n, input int hi, input int lo);
    int t0;
    wave.delete();
    @(negedge clk);
    t0 = cyc + 1;
    for (int j = 0; j < n; j++) begin
      qbusy.push_back(t0 + wave.size() + hi + 2);
      repeat (hi) wave.push_back(1'b1);
      repeat (lo) wave.push_back(1'b0);
    end
    repeat (6) wave.push_back(1'b0);
    play(t0, 0, 0);
  endtask

  // Reset lands while b is high; the still-held button must yield a fresh request.
  task automatic reset_mid_req();
    int t0, e, er, e2, n;
    bexp_t x;
    wave.delete();
    @(negedge clk);
    t0 = cyc + 1;
    e  = t0 + D + 2;
    er = e + 3;
    e2 = er + D + 3;
    x.rise = e;
    x.width = 3;
    x.cnt = 0;
    qb.push_back(x);
    qbusy.push_back(er);
    model_cnt = 1;
    x.rise = e2;
    x.width = 1;
    x.cnt = 1;
    qb.push_back(x);
    n = e2 + 4 - t0;
    repeat (n) wave.push_back(1'b1);
    qbusy.push_back(t0 + n + 2 + D + H);
    repeat (2 + D + H + 4) wave.push_back(1'b0);
    play(t0, er + 1, er);
  endtask

  initial begin
    int k, lh;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_b", int'(b), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_press_cnt", int'(press_cnt), 0);
    chk("reset_long_press", int'(long_press), 0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    press(0, 100, 1, 0);
    bounce_only(6, 5, 5);
    chk("bounce_press_cnt", int'(press_cnt), 1);
    press(0, D + 7 + 1 + $urandom_range(10, 0), 7, 0);
    press(0, 200, 1, 0);
    press(0, 30, 1, 0);

    while (model_cnt != 0) begin
      k  = ($urandom_range(3, 0) == 0) ? $urandom_range(6, 2) : 1;
      lh = D + k + 1 + (($urandom_range(7, 0) == 0) ? $urandom_range(120, 0) : $urandom_range(15, 0));
      press($urandom_range(2, 0), lh, k, $urandom_range(2, 0));
    end
    @(negedge clk);
    chk("wrap_press_cnt", int'(press_cnt), 0);

    press(1, D + 4, 1, 0);
    reset_mid_req();

    repeat (5) @(negedge clk);
    chk("pending_b_events", qb.size(), 0);
    chk("pending_busy_events", qbusy.size(), 0);
    chk("pending_long_events", qlong.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/street_light_btn_tx.md
# street_light_btn_tx

- Transmit end of the `b` request input of the street light system.
- Takes a raw, asynchronous, bouncy push-button and produces one clean request on `b` per physical press.
- Synchronizes and debounces the button, then holds `b` under a req/ack handshake and enforces release plus hold-off before the next request.
- Sits between the board button pin and the light controller's `b` input; tie `ack` high when the consumer has no acknowledge, which gives a one-cycle pulse.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized samples required to accept a press or a release (legal 2..255).
- HOLDOFF_CYCLES, 8: dead time after an accepted release before a new press is considered (legal 1..255).
- LONG_CYCLES, 64: held-high duration that flags a long press (only used with the macro; legal 1..65535).

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- btn_raw  in  1  raw button, asynchronous to clk, active-high.
- ack  in  1  consumer acknowledge, sampled on clk.
- b  out  1  request to the light system, registered.
- busy  out  1  high in every state except IDLE.
- press_cnt  out  8  count of acknowledged requests, wraps 255 -> 0.
- long_press  out  1  one-cycle long-press flag; constant 0 without the macro.

## Operation
- **Synchronizer:** two-flop chain `btn_raw` -> `s1` -> `btn_s`. Only `btn_s` feeds the logic.
- **FSM states:** IDLE, DB_PRESS, REQ, WAIT_REL, DB_REL, HOLDOFF.
- **IDLE:** `btn_s`=1 -> DB_PRESS with the counter loaded to 1.
- **DB_PRESS:** each `btn_s`=1 sample increments the counter. Any `btn_s`=0 sample -> IDLE, counter cleared (the bounce is rejected). Counter reaching DEBOUNCE_CYCLES -> REQ.
- **REQ:**
  - `b`=1 for every cycle the FSM is in REQ.
  - `ack` is sampled starting on the first edge after REQ entry, so `b` is high for at least one cycle even if `ack` is already high.
  - `ack`=1 at an edge -> WAIT_REL, `b`=0 from that edge, `press_cnt`+1.
  - `btn_raw` activity while in REQ is ignored.
- **WAIT_REL:** `btn_s`=0 -> DB_REL with the counter loaded to 1.
- **DB_REL:** each `btn_s`=0 sample increments the counter. Any `btn_s`=1 sample -> WAIT_REL. Counter reaching DEBOUNCE_CYCLES -> HOLDOFF.
- **HOLDOFF:** counts HOLDOFF_CYCLES edges, ignoring the button, then -> IDLE. A button still or again held at that point starts a fresh DB_PRESS.
- **Arithmetic:** debounce and hold-off counters are 8 bits and saturate; they never wrap. `press_cnt` wraps modulo 256.
- **Reset (synchronous):** while `rst_n`=0 at an edge:
  - state = IDLE; `s1`, `btn_s`, counters, `press_cnt` all = 0.
  - `b`=0, `busy`=0, `long_press`=0 from that edge.
  - A reset asserted mid-REQ drops `b` with no count.
  - A button held across reset release is debounced as a new press.

## Timing
- **Press latency:** with `btn_raw` rising cleanly before edge 1, `b` is first high after edge DEBOUNCE_CYCLES+3 (edge 19 at defaults).
  - Edges 1-2: synchronizer.
  - Edges 3..DEBOUNCE_CYCLES+2: debounce samples.
  - Next edge: REQ.
- **Ack latency:** `b` falls on the first edge at which `ack`=1, counting from the edge after REQ entry. With `ack` tied 1, `b` is exactly one cycle wide.
- **Release latency:** `busy` falls after the release edge + 2 + DEBOUNCE_CYCLES + HOLDOFF_CYCLES edges.
- **Minimum spacing:** press-to-press spacing is at least 2·DEBOUNCE_CYCLES + HOLDOFF_CYCLES + 1 cycles.

## Configuration
- Macro: **STREET_LIGHT_LONG_PRESS_EN**.
- **Defined:**
  - A 16-bit hold counter clears on REQ entry and increments every cycle `btn_s`=1 while in REQ, WAIT_REL or DB_REL.
  - It clears on any `btn_s`=0 sample.
  - When it reaches LONG_CYCLES, `long_press` pulses high for exactly one cycle, at most once per press.
  - The counter then saturates until the next REQ entry.
- **Undefined:** `long_press` is driven constant 0 and no hold counter exists. All other behaviour is identical.

## Test plan
- **Clean press, `ack`=1:** `btn_raw` 0->1 held 100 cycles, then 0. Required: `b` high for exactly cycle 19 only; `press_cnt`=1; `busy` low 2+16+8 cycles after release.
- **Bounce rejection:** `btn_raw` toggles 1/0 with 5-cycle high periods for 60 cycles, then 0. Required: `b` never asserts; `press_cnt`=0; `busy` returns to 0.
- **Held ack handshake:** press with `ack`=0, raise `ack` 7 cycles after `b` rises. Required: `b` high exactly 7 cycles, falls on the `ack` edge; `press_cnt`+1.
- **Wrap and reset mid-request:**
  - 256 clean presses -> `press_cnt`=0.
  - Then `rst_n`=0 for one edge while `b`=1 -> `b`=0, `press_cnt`=0 next cycle.
  - The held button produces a new `b` after 16+3 cycles.
- **Long press (macro defined):** button held 200 cycles with `ack`=1. Required: one `long_press` pulse 64 cycles after REQ entry; a 30-cycle press yields none. With the macro undefined, `long_press` stays 0 throughout.
